// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and defaults for the adder-sharing arbiter.
// Holds the FSM state type, parameter defaults and the tag-width helper.
package adder_share_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 4;

  // Tag width never drops below one bit, even for a single requester.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
// Build option: ADDER_SHARE_FIXED_PRIO_EN selects lowest-index-wins priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int   j;
  logic found;

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
`ifdef ADDER_SHARE_FIXED_PRIO_EN
      j = o;
`else
      // Search upward from the pointer, wrapping past the top requester.
      j = (int'(ptr) + o) % NUM_REQ;
`endif
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One DATA_W-bit adder shared by NUM_REQ requesters; tagged, held result.
// Build option: ADDER_SHARE_FIXED_PRIO_EN (fixed priority, no rr pointer).
//
// state  | meaning
// IDLE   | no result held, res_valid=0
// RESULT | result held until res_valid && res_ready
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] a_flat,
  input  logic [NUM_REQ*DATA_W-1:0] b_flat,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W:0]           res_sum,
  output logic [ID_W-1:0]           res_id
);

  state_t            state, state_next;
  logic              slot_free;
  logic              any_gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_ptr;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [DATA_W:0]   sum;

  // res_ready reaches gnt only through slot_free.
  assign slot_free = (state == IDLE) || res_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .en  (slot_free && rst_n),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign any_gnt = |gnt;

  always_comb begin
    a_sel = a_flat[int'(gnt_idx)*DATA_W +: DATA_W];
    b_sel = b_flat[int'(gnt_idx)*DATA_W +: DATA_W];
    sum   = {1'b0, a_sel} + {1'b0, b_sel};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_gnt) state_next = RESULT;
      RESULT:  if (res_ready && !any_gnt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      res_sum <= '0;
      res_id  <= '0;
    end else begin
      state <= state_next;
      if (any_gnt) begin
        res_sum <= sum;
        res_id  <= gnt_idx;
      end
    end
  end

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  assign res_valid = (state == RESULT);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter against a queue-free reference model.
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_flat = '0;
  logic [N*W-1:0] b_flat = '0;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W:0]     res_sum;
  logic [1:0]     res_id;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int           m_ptr = 0;
  bit           m_valid = 0;
  int           m_sum = 0;
  int           m_id = 0;
  logic [N-1:0] exp_gnt;

  adder_share_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int start;
    g = '0;
    if (!rst_n || req == '0 || (m_valid && !res_ready)) return g;
`ifdef ADDER_SHARE_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int o = 0; o < N; o++) begin
      if (req[(start + o) % N]) begin
        g[(start + o) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic drive(input bit rst, input logic [N-1:0] r,
                       input logic [N*W-1:0] a, input logic [N*W-1:0] b, input bit rdy);
    rst_n = rst; req = r; a_flat = a; b_flat = b; res_ready = rdy;
    @(negedge clk);
    exp_gnt = model_gnt();
  endtask

  task automatic tick();
    int k;
    k = -1;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) k = i;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0;
    end else if (k >= 0) begin
      m_sum   = int'(a_flat[k*W +: W]) + int'(b_flat[k*W +: W]);
      m_id    = k;
      m_valid = 1;
      m_ptr   = (k + 1) % N;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  function automatic logic [N*W-1:0] rnd_ops();
    return {$urandom, $urandom} & {(N*W){1'b1}};
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 4'b1111, rnd_ops(), rnd_ops(), 1);
      checks++;
      if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      tick();
    end
    checks++;
    if (res_valid !== 1'b0 || res_sum !== 5'd0 || res_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b sum=%0d id=%0d exp 0/0/0", res_valid, res_sum, res_id);
    end
    drive(1, 4'b1111, rnd_ops(), rnd_ops(), 1);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    tick();
    drive(1, 4'b0000, '0, '0, 1);
    tick();
  endtask

  task automatic test_single();
    logic [N*W-1:0] a, b;
    a = '0; b = '0;
    a[2*W +: W] = 4'd3; b[2*W +: W] = 4'd5;
    drive(1, 4'b0100, a, b, 1);
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    tick();
    drive(1, 4'b0000, '0, '0, 1);
    checks++;
    if (res_valid !== 1'b1 || res_sum !== 5'd8 || res_id !== 2'd2) begin
      failures++;
      $display("FAIL single_result got valid=%b sum=%0d id=%0d exp 1/8/2", res_valid, res_sum, res_id);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    drive(0, 4'b0000, '0, '0, 1);
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1, 4'b1111, rnd_ops(), rnd_ops(), 1);
`ifdef ADDER_SHARE_FIXED_PRIO_EN
      want = 4'b0001;
`else
      want = 4'b0001 << (c % 4);
`endif
      checks++;
      if (gnt !== want || gnt !== exp_gnt) begin
        failures++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt, want);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(m_id) || res_sum !== 5'(m_sum)) begin
        failures++;
        $display("FAIL rr_result cycle=%0d got id=%0d sum=%0d exp id=%0d sum=%0d", c, res_id, res_sum, m_id, m_sum);
      end
    end
    drive(1, 4'b0000, '0, '0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [W:0] held_sum;
    logic [1:0] held_id;
    drive(1, 4'b0011, rnd_ops(), rnd_ops(), 1);
    tick();
    held_sum = 5'(m_sum); held_id = 2'(m_id);
    for (int c = 0; c < 4; c++) begin
      drive(1, 4'b0011, rnd_ops(), rnd_ops(), 0);
      checks++;
      if (gnt !== 4'b0000 || res_valid !== 1'b1 || res_sum !== held_sum || res_id !== held_id) begin
        failures++;
        $display("FAIL stall cycle=%0d got gnt=%b v=%b sum=%0d id=%0d exp gnt=0000 v=1 sum=%0d id=%0d",
                 c, gnt, res_valid, res_sum, res_id, held_sum, held_id);
      end
      tick();
    end
    drive(1, 4'b0011, rnd_ops(), rnd_ops(), 1);
    checks++;
    if (gnt === 4'b0000 || gnt !== exp_gnt) begin
      failures++; $display("FAIL stall_release_gnt got=%b exp=%b", gnt, exp_gnt);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'(m_id) || res_sum !== 5'(m_sum)) begin
      failures++; $display("FAIL stall_release_result got id=%0d sum=%0d exp id=%0d sum=%0d", res_id, res_sum, m_id, m_sum);
    end
    drive(1, 4'b0000, '0, '0, 1);
    tick();
  endtask

  task automatic test_carry();
    logic [W-1:0] av[3] = '{4'd15, 4'd15, 4'd0};
    logic [W-1:0] bv[3] = '{4'd15, 4'd1, 4'd0};
    logic [W:0]   sv[3] = '{5'd30, 5'd16, 5'd0};
    logic [N*W-1:0] a, b;
    for (int c = 0; c < 3; c++) begin
      a = rnd_ops(); b = rnd_ops();
      a[1*W +: W] = av[c]; b[1*W +: W] = bv[c];
      drive(1, 4'b0010, a, b, 1);
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_sum !== sv[c] || res_id !== 2'd1) begin
        failures++; $display("FAIL carry case=%0d got sum=%0d id=%0d exp sum=%0d id=1", c, res_sum, res_id, sv[c]);
      end
    end
    drive(1, 4'b0000, '0, '0, 1);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 4'b1000, rnd_ops(), rnd_ops(), 1);
    tick();
    drive(1, 4'b0000, '0, '0, 0);
    tick();
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre got valid=%b exp=1", res_valid); end
    drive(0, 4'b1111, rnd_ops(), rnd_ops(), 0);
    tick();
    drive(1, 4'b1111, rnd_ops(), rnd_ops(), 1);
    checks++;
    if (res_valid !== 1'b0 || gnt !== 4'b0001) begin
      failures++; $display("FAIL midreset_post got valid=%b gnt=%b exp valid=0 gnt=0001", res_valid, gnt);
    end
    tick();
    drive(1, 4'b0000, '0, '0, 1);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), N'($urandom), rnd_ops(), rnd_ops(),
            ($urandom_range(0, 9) < 7));
      checks++;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt cycle=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      checks++;
      if (res_valid !== m_valid || res_sum !== 5'(m_sum) || res_id !== 2'(m_id)) begin
        failures++;
        $display("FAIL rand_out cycle=%0d got v=%b sum=%0d id=%0d exp v=%b sum=%0d id=%0d",
                 c, res_valid, res_sum, res_id, m_valid, m_sum, m_id);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_carry();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one DATA_W-bit unsigned adder among NUM_REQ requesters using round-robin arbitration.
- Each requester presents two operands and a request. The block grants one requester per cycle, registers the (DATA_W+1)-bit sum, and tags it with the requester index.
- The tagged result is held until downstream accepts it through a valid/ready handshake.
- Sits between several producer blocks and a single shared arithmetic resource and its result consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width in bits; sum width is DATA_W+1.
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester request; bit i belongs to requester i.
- a_flat  in  NUM_REQ*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- b_flat  in  NUM_REQ*DATA_W  operand B; same packing as a_flat.
- gnt  out  NUM_REQ  one-hot grant; operands of the granted requester are captured at the same edge.
- res_valid  out  1  registered result valid.
- res_ready  in  1  downstream accepts the result when res_valid && res_ready.
- res_sum  out  DATA_W+1  registered a+b, zero-extended; carry is in the MSB.
- res_id  out  ID_W  index of the requester that produced res_sum.

Behaviour:
- Reset: clk and rst_n only; reset is synchronous, active-low, sampled at the rising edge. While rst_n=0 at an edge, the block loads:
  - res_valid=0, res_sum=0, res_id=0, rr_ptr=0, state=IDLE.
  - gnt is forced to 0 while rst_n=0.
  - A reset mid-operation discards any held result without a handshake.
- slot_free = (state==IDLE) || res_ready. This is the only combinational path from res_ready to gnt.
- Grant, combinational:
  - If slot_free and req!=0, gnt is one-hot: the first set req bit searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Otherwise gnt=0.
- On a clock edge with gnt[k]=1:
  - res_sum <= a_k + b_k at full DATA_W+1 width; no truncation, no saturation.
  - res_id <= k; res_valid <= 1.
  - rr_ptr <= (k+1) mod NUM_REQ.
- Latency: exactly 1 cycle from gnt to res_valid.
- Throughput: one result per cycle while res_ready is held at 1.
- FSM states:
  - IDLE: res_valid=0.
    - Grant -> RESULT.
    - Otherwise stay in IDLE.
  - RESULT: res_valid=1; res_sum and res_id are stable.
    - res_ready=0 -> stay; outputs held; gnt=0.
    - res_ready=1 with a new grant -> stay in RESULT with the new data (back-to-back).
    - res_ready=1 with no request -> IDLE; res_valid=0; res_sum and res_id keep their last values.
- Requester rules:
  - A requester holds req and its operands stable until it sees gnt.
  - It may keep req high to issue further operations.
  - Deasserting req before grant withdraws the request; nothing is recorded.
- Simultaneous requests: exactly one grant per cycle. No requester waits more than NUM_REQ-1 grants.
- rr_ptr changes only on a grant. Idle cycles and stalls leave it unchanged.
- Overflow example: a=4'hF, b=4'hF gives res_sum=5'h1E.

Optional Feature:
- Macro: ADDER_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index set req bit always wins, and rr_ptr is not implemented.
- Undefined (default): round-robin as described above.
- All ports, timing and handshake behaviour are identical in both builds.

Decomposition:
- Package adder_share_pkg holds:
  - the FSM state typedef (IDLE, RESULT);
  - default constants for NUM_REQ and DATA_W;
  - an id-width function wrapping $clog2 with a minimum of 1.
- One sub-module: rr_arbiter, parameterised by NUM_REQ.
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt and an encoded grant index.
  - Purely combinational.
  - The macro selects its fixed-priority variant.
- Operand muxing, the adder, the output register and the FSM stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles while req=4'b1111 -> gnt=0, res_valid=0, res_sum=0, res_id=0; first post-reset grant is gnt=4'b0001.
2. Single op: req=4'b0100, a2=3, b2=5, res_ready=1 -> gnt=4'b0100 in that cycle; next cycle res_valid=1, res_sum=5'd8, res_id=2.
3. Round-robin fairness: req=4'b1111 held, res_ready=1, 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; res_id 0,1,2,3,0,1,2,3.
4. Backpressure: a result is valid, res_ready=0 for 4 cycles with req=4'b0011 -> gnt=0, res_sum and res_id stable; res_ready=1 -> result accepted and a new grant issued in the same cycle.
5. Carry: a=15, b=15 -> res_sum=5'd30; a=15, b=1 -> res_sum=5'd16; a=0, b=0 -> res_sum=0.
6. Reset mid-stall: res_valid=1, res_ready=0, then rst_n=0 for 1 cycle -> res_valid=0 next cycle and rr_ptr=0. With ADDER_SHARE_FIXED_PRIO_EN defined, rerun scenario 3 -> gnt=0001 every cycle.
